// File: rtl/pipe_mem.sv
// Memory-access stage: one data access per execute result, lane steering,
// load extension and a registered valid/ready result toward writeback.
module pipe_mem #(
   parameter int REG_SZ = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_SZ-1:0] ans_in,
   input  logic [REG_SZ-1:0] dout_in,
   input  logic [1:0]        rw_e_in,
   input  logic [1:0]        rw_len_in,
   input  logic              ld_uns_in,
   input  logic              wb_e_in,
   input  logic [4:0]        wb_idx_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [REG_SZ-1:0] mem_wdata,
   input  logic [REG_SZ-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wb_e_out,
   output logic [4:0]        wb_idx_out,
   output logic [REG_SZ-1:0] wb_data_out,
   output logic              misalign
);

   typedef enum logic [1:0] {IDLE, MEM, OUT} state_t;

   state_t            state, state_nx;
   logic              xfer;
   logic              acc;
   logic              aligned;
   logic              go_mem;
   logic              mis;
   logic [3:0]        be_in;
   logic [REG_SZ-1:0] wdata_in;

   logic [REG_SZ-1:0] ans_q;
   logic [1:0]        len_q;
   logic              uns_q;
   logic              ld_q;
   logic              wb_e_q;

   logic [7:0]        ld_b;
   logic [15:0]       ld_h;
   logic [REG_SZ-1:0] ld_ext;

   always_comb begin
      acc      = (rw_e_in == 2'b01) || (rw_e_in == 2'b10);
      aligned  = 1'b0;
      be_in    = 4'b1111;
      wdata_in = dout_in;
      unique case (rw_len_in)
         2'b00: begin
            aligned  = 1'b1;
            be_in    = 4'b0001 << ans_in[1:0];
            wdata_in = {4{dout_in[7:0]}};
         end
         2'b01: begin
            aligned  = ~ans_in[0];
            be_in    = ans_in[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{dout_in[15:0]}};
         end
         2'b10: begin
            aligned  = (ans_in[1:0] == 2'b00);
            be_in    = 4'b1111;
            wdata_in = dout_in;
         end
         default: begin
            aligned  = 1'b0;
            be_in    = 4'b1111;
            wdata_in = dout_in;
         end
      endcase
      go_mem = acc & aligned;
      mis    = acc & ~aligned;
   end

   // load lane selection works off the latched byte address
   always_comb begin
      ld_b = 8'h00;
      unique case (ans_q[1:0])
         2'd0: ld_b = mem_rdata[7:0];
         2'd1: ld_b = mem_rdata[15:8];
         2'd2: ld_b = mem_rdata[23:16];
         2'd3: ld_b = mem_rdata[31:24];
         default: ld_b = 8'h00;
      endcase
      ld_h = ans_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      unique case (len_q)
         2'b00: ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
         2'b01: ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      unique case (state)
         IDLE:    in_ready = 1'b1;
         OUT:     in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
      xfer = in_valid & in_ready;
      if (xfer)
         state_nx = go_mem ? MEM : OUT;
      else if (state == MEM && mem_ack)
         state_nx = OUT;
      else if (state == OUT && out_ready)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_be      <= 4'b0000;
         mem_wdata   <= '0;
         out_valid   <= 1'b0;
         wb_e_out    <= 1'b0;
         wb_idx_out  <= 5'd0;
         wb_data_out <= '0;
         misalign    <= 1'b0;
         ans_q       <= '0;
         len_q       <= 2'b00;
         uns_q       <= 1'b0;
         ld_q        <= 1'b0;
         wb_e_q      <= 1'b0;
      end else if (xfer) begin
         ans_q      <= ans_in;
         len_q      <= rw_len_in;
         uns_q      <= ld_uns_in;
         ld_q       <= (rw_e_in == 2'b01);
         wb_e_q     <= wb_e_in;
         wb_idx_out <= wb_idx_in;
         if (go_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= (rw_e_in == 2'b10);
            mem_addr  <= {ans_in[ADDR_W-1:2], 2'b00};
            mem_be    <= be_in;
            mem_wdata <= wdata_in;
            out_valid <= 1'b0;
            misalign  <= 1'b0;
         end else begin
            // faulted accesses never write back
            out_valid   <= 1'b1;
            wb_data_out <= ans_in;
            wb_e_out    <= wb_e_in & ~mis;
            misalign    <= mis;
         end
      end else if (state == MEM && mem_ack) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         out_valid   <= 1'b1;
         wb_e_out    <= wb_e_q;
         wb_data_out <= ld_q ? ld_ext : ans_q;
         misalign    <= 1'b0;
      end else if (state == OUT && out_ready) begin
         out_valid <= 1'b0;
         misalign  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_mem.sv
// Bench for pipe_mem: directed cases plus random traffic against a
// transaction-level model of the stage and a randomly slow memory.
module tb_pipe_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] ans_in;
   logic [31:0] dout_in;
   logic [1:0]  rw_e_in;
   logic [1:0]  rw_len_in;
   logic        ld_uns_in;
   logic        wb_e_in;
   logic [4:0]  wb_idx_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        out_valid;
   logic        out_ready;
   logic        wb_e_out;
   logic [4:0]  wb_idx_out;
   logic [31:0] wb_data_out;
   logic        misalign;

   pipe_mem #(.REG_SZ(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .ans_in(ans_in), .dout_in(dout_in),
      .rw_e_in(rw_e_in), .rw_len_in(rw_len_in),
      .ld_uns_in(ld_uns_in), .wb_e_in(wb_e_in), .wb_idx_in(wb_idx_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .out_valid(out_valid), .out_ready(out_ready),
      .wb_e_out(wb_e_out), .wb_idx_out(wb_idx_out),
      .wb_data_out(wb_data_out), .misalign(misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          needs_mem;
      bit          acked;
      logic [31:0] addr;
      logic [3:0]  be;
      bit          we;
      logic [31:0] wdata;
      bit          is_load;
      bit          uns;
      int          sz;
      int          lane;
      bit          wb_e;
      logic [4:0]  idx;
      logic [31:0] data;
      bit          mis;
   } item_t;

   item_t       cur;
   bit          cur_v;
   bit          mr_e, ov_e, exp_ir, last_xfer;
   int          n_vec, n_bad;
   bit          rmode, force_ack;
   int          req_cnt, ack_tgt;
   logic [31:0] rd_fix;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic item_t make_item();
      item_t it;
      bit    acc;
      bit    al;
      acc = (rw_e_in == 2'd1) || (rw_e_in == 2'd2);
      it.sz = (rw_len_in == 2'd3) ? 0 : (1 << rw_len_in);
      al = (it.sz != 0) && ((ans_in % it.sz) == 0);
      it.lane = int'(ans_in % 4);
      it.needs_mem = acc && al;
      it.mis = acc && !al;
      it.acked = 1'b0;
      it.addr = ans_in & ~32'd3;
      it.be = 4'(((1 << it.sz) - 1) << it.lane);
      it.we = (rw_e_in == 2'd2);
      if (it.sz == 1)
         it.wdata = 32'(dout_in[7:0] * 32'h01010101);
      else if (it.sz == 2)
         it.wdata = 32'(dout_in[15:0] * 32'h00010001);
      else
         it.wdata = dout_in;
      it.is_load = (rw_e_in == 2'd1);
      it.uns = ld_uns_in;
      it.wb_e = wb_e_in && !it.mis;
      it.idx = wb_idx_in;
      it.data = ans_in;
      return it;
   endfunction

   function automatic logic [31:0] ld_val(input logic [31:0] rd,
                                          input item_t it);
      logic [31:0] mask;
      logic [31:0] v;
      mask = (it.sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * it.sz)) - 32'd1);
      v = (rd >> (8 * it.lane)) & mask;
      if (!it.uns && it.sz < 4 && v[8 * it.sz - 1]) v = v | ~mask;
      return v;
   endfunction

   task automatic sample();
      @(negedge clk);
      mr_e = cur_v && cur.needs_mem && !cur.acked;
      ov_e = cur_v && (!cur.needs_mem || cur.acked);
      chk("mem_req", 32'(mem_req), 32'(mr_e));
      chk("out_valid", 32'(out_valid), 32'(ov_e));
      if (mr_e) begin
         chk("mem_addr", mem_addr, cur.addr);
         chk("mem_be", 32'(mem_be), 32'(cur.be));
         chk("mem_we", 32'(mem_we), 32'(cur.we));
         if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (ov_e) begin
         chk("wb_e_out", 32'(wb_e_out), 32'(cur.wb_e));
         chk("wb_idx_out", 32'(wb_idx_out), 32'(cur.idx));
         chk("wb_data_out", wb_data_out, cur.data);
         chk("misalign", 32'(misalign), 32'(cur.mis));
      end else begin
         chk("misalign_idle", 32'(misalign), 32'd0);
      end
   endtask

   task automatic tick();
      if (mem_req) begin
         if (rmode && req_cnt == 0) ack_tgt = $urandom_range(0, 4);
         mem_ack = (req_cnt >= ack_tgt);
         mem_rdata = rmode ? $urandom : rd_fix;
         req_cnt++;
      end else begin
         req_cnt = 0;
         mem_ack = rmode ? ($urandom_range(0, 4) == 0) : force_ack;
         mem_rdata = $urandom;
      end
      #1;
      exp_ir = !cur_v || (ov_e && out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      if (mr_e && mem_ack) begin
         cur.acked = 1'b1;
         if (cur.is_load) cur.data = ld_val(mem_rdata, cur);
      end
      last_xfer = in_valid && exp_ir;
      if (ov_e && out_ready) cur_v = 1'b0;
      if (last_xfer) begin
         cur = make_item();
         cur_v = 1'b1;
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] e,
                        input logic [1:0] l, input bit u, input bit w,
                        input logic [4:0] i);
      in_valid = v; ans_in = a; dout_in = d; rw_e_in = e;
      rw_len_in = l; ld_uns_in = u; wb_e_in = w; wb_idx_in = i;
   endtask

   task automatic wait_ov(input string nm);
      int n;
      n = 0;
      sample();
      while (!out_valid && n < 40) begin
         in_valid = 1'b0;
         tick();
         sample();
         n++;
      end
      if (n >= 40) chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      n_vec = 0; n_bad = 0; cur_v = 1'b0;
      rmode = 1'b0; force_ack = 1'b0; req_cnt = 0; ack_tgt = 3;
      rd_fix = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      out_ready = 1'b1; last_xfer = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_wb_data", wb_data_out, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      rst = 1'b1;

      // ALU passthrough, back-to-back
      sample(); drive(1, 5, 0, 0, 0, 0, 1, 3); tick();
      sample(); chk("pt_5", wb_data_out, 32'd5);
      ans_in = 6; tick();
      sample(); chk("pt_6", wb_data_out, 32'd6);
      ans_in = 7; tick();
      sample(); chk("pt_7", wb_data_out, 32'd7);
      chk("pt_ir", 32'(in_ready), 32'd1);
      in_valid = 1'b0; tick();

      // signed then unsigned byte load
      rd_fix = 32'h0080_0000; ack_tgt = 3;
      sample(); drive(1, 32'h1002, 0, 1, 0, 0, 1, 4); tick();
      sample(); chk("ld_addr", mem_addr, 32'h1000);
      chk("ld_be", 32'(mem_be), 32'h4);
      in_valid = 1'b0; tick();
      wait_ov("ld_s");
      chk("ld_signed", wb_data_out, 32'hFFFF_FF80);
      drive(1, 32'h1002, 0, 1, 0, 1, 1, 4); tick();
      sample(); in_valid = 1'b0; tick();
      wait_ov("ld_u");
      chk("ld_unsigned", wb_data_out, 32'h0000_0080);
      in_valid = 1'b0; tick();

      // half store
      sample(); drive(1, 32'h2002, 32'h0000_BEEF, 2, 1, 0, 0, 0); tick();
      sample(); chk("st_we", 32'(mem_we), 32'd1);
      chk("st_be", 32'(mem_be), 32'hC);
      chk("st_wdata", mem_wdata, 32'hBEEF_BEEF);
      in_valid = 1'b0; tick();
      wait_ov("st");
      chk("st_wb", wb_data_out, 32'h2002);
      in_valid = 1'b0; tick();

      // misaligned word load, then backpressure
      sample(); drive(1, 32'h3001, 0, 1, 2, 0, 1, 9); tick();
      sample(); chk("mis_req", 32'(mem_req), 32'd0);
      chk("mis_flag", 32'(misalign), 32'd1);
      chk("mis_wbe", 32'(wb_e_out), 32'd0);
      out_ready = 1'b0;
      drive(1, 32'h55, 0, 0, 0, 0, 1, 2); tick();
      repeat (4) begin
         sample();
         chk("bp_ir", 32'(in_ready), 32'd0);
         chk("bp_hold", wb_data_out, 32'h3001);
         tick();
      end
      sample(); out_ready = 1'b1; tick();
      sample(); chk("bp_next", wb_data_out, 32'h55);
      in_valid = 1'b0; tick();

      // reset during an outstanding access
      ack_tgt = 100;
      sample(); drive(1, 32'h40, 0, 1, 2, 0, 1, 1); tick();
      sample(); chk("rm_req", 32'(mem_req), 32'd1);
      in_valid = 1'b0; tick();
      sample();
      #2 rst = 1'b0;
      #1 chk("rm_req_drop", 32'(mem_req), 32'd0);
      chk("rm_ov_drop", 32'(out_valid), 32'd0);
      cur_v = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      sample(); force_ack = 1'b1; tick();
      sample(); chk("late_ack_req", 32'(mem_req), 32'd0);
      chk("late_ack_ov", 32'(out_valid), 32'd0);
      force_ack = 1'b0; ack_tgt = 3;
      tick();

      // random traffic
      rmode = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         sample();
         if (!(in_valid && !last_xfer)) begin
            drive($urandom_range(0, 9) < 7, $urandom, $urandom,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
